// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign codes,
// opcode constants, the controller state type and size decoding.
package lsu_pkg;

  // funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Direction of an access as carried on req_we
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // Access size in bytes; 0 for an undefined size code.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

  // Legal codes: all five for loads, only the signed-width codes for stores.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = (we == OP_LOAD);
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable mask over two words, store data
// lane shift with masked-off lanes zeroed, and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  output logic        cross_o,
  output logic [7:0]  mask_o,
  output logic [63:0] sdata_o,
  output logic [31:0] ldata_o
);

  logic [2:0]  size;
  logic [7:0]  base_mask;
  logic [63:0] shifted;
  logic [63:0] loaded;
  logic [31:0] raw;
  logic        sign_ext;

  // Mask, store shift and load extraction for the current access
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    base_mask = 8'h00;
    sdata_o   = '0;
    ldata_o   = '0;

    size     = size_bytes(funct3_i);
    sign_ext = ~funct3_i[2];

    case (size)
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      3'd4:    base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
    mask_o  = base_mask << off_i;
    cross_o = ({2'b00, off_i} + {1'b0, size}) > 4'd4;

    shifted = {32'h0, wdata_i} << {off_i, 3'b000};
    for (int i = 0; i < 8; i++) begin
      sdata_o[8*i +: 8] = mask_o[i] ? shifted[8*i +: 8] : 8'h00;
    end

    loaded = {hi_word_i, lo_word_i} >> {off_i, 3'b000};
    raw    = loaded[31:0];
    case (size)
      3'd1:    ldata_o = {{24{sign_ext & raw[7]}}, raw[7:0]};
      3'd2:    ldata_o = {{16{sign_ext & raw[15]}}, raw[15:0]};
      3'd4:    ldata_o = raw;
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_split_access.sv
// Load/store unit front end: accepts one pipeline access at a time, issues
// one or two word-aligned memory beats, and returns an extended load result.
module lsu_split_access
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_mask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;

  // Captured request
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic              second_q;
  logic [31:0]       beat1_q;

  // Registered outputs
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_mask_q;
  logic [31:0]       mem_wdata_q;

  // Align-unit operands and results
  logic              idle;
  logic [2:0]        al_funct3;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata;
  logic [31:0]       al_lo;
  logic [31:0]       al_hi;
  logic              al_cross;
  logic [7:0]        al_mask;
  logic [63:0]       al_sdata;
  logic [31:0]       al_ldata;

  logic              req_err;
  logic              req_split;
  logic [ADDR_W-3:0] word_next;
  logic [ADDR_W-1:0] beat2_addr_d;

  // Align unit sees the live request in IDLE and the captured one afterwards
  always_comb begin
    idle      = (state_q == ST_IDLE);
    al_funct3 = idle ? req_funct3     : funct3_q;
    al_off    = idle ? req_addr[1:0]  : addr_q[1:0];
    al_wdata  = idle ? req_wdata      : wdata_q;
    al_lo     = split_q ? beat1_q   : mem_rdata;
    al_hi     = split_q ? mem_rdata : 32'h0;
  end

  lsu_align u_align (
    .funct3_i  (al_funct3),
    .off_i     (al_off),
    .wdata_i   (al_wdata),
    .lo_word_i (al_lo),
    .hi_word_i (al_hi),
    .cross_o   (al_cross),
    .mask_o    (al_mask),
    .sdata_o   (al_sdata),
    .ldata_o   (al_ldata)
  );

  // Request classification and the wrapping second-beat address
  always_comb begin
    req_err      = !funct3_legal(req_we, req_funct3) || (al_cross && (MISALIGN_EN == 0));
    req_split    = al_cross && (MISALIGN_EN != 0);
    word_next    = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
    beat2_addr_d = {word_next, 2'b00};
  end

  // Controller: request capture, beat sequencing and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the beat-1 buffer is a plain register, so it is cleared with
      // everything else; a stale half-word never leaks into a later load.
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      split_q     <= 1'b0;
      second_q    <= 1'b0;
      beat1_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_mask_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch
      // reads the pre-edge values, matching the flip-flops being built.
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            split_q  <= req_split;
            second_q <= 1'b0;
            ready_q  <= 1'b0;
            if (req_err) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q     <= ST_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_mask_q  <= al_mask[3:0];
              mem_wdata_q <= al_sdata[31:0];
            end
          end
        end

        ST_ISSUE: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            if (split_q && !second_q) begin
              beat1_q     <= mem_rdata;
              second_q    <= 1'b1;
              state_q     <= ST_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_q;
              mem_addr_q  <= beat2_addr_d;
              mem_mask_q  <= al_mask[7:4];
              mem_wdata_q <= al_sdata[63:32];
            end else begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              rdata_q <= (we_q == OP_STORE) ? 32'h0 : al_ldata;
            end
          end
        end

        ST_RESP: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_mask  = mem_mask_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: a single-access driver with a
// scripted memory responder, plus a second instance with splitting disabled.
module tb_lsu_split_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_na;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        ready_na, done_na, err_na;
  logic [31:0] rdata_na;
  logic        mem_req_na, mem_we_na;
  logic [31:0] mem_addr_na;
  logic [3:0]  mem_mask_na;
  logic [31:0] mem_wdata_na;
  logic        mem_gnt_na, mem_rvalid_na;
  logic [31:0] mem_rdata_na;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent run_access
  logic [31:0] b_addr  [2];
  logic [3:0]  b_mask  [2];
  logic [31:0] b_wdata [2];
  logic        b_we    [2];
  int          lat, nbeats, stab_bad;
  logic [31:0] res_rdata;
  logic        res_err, req_seen;

  always #5 clk = ~clk;

  lsu_split_access #(.ADDR_W(32), .MISALIGN_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_split_access #(.ADDR_W(32), .MISALIGN_EN(0)) u_dut_na (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_na), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready_na), .done(done_na), .err(err_na), .rdata(rdata_na),
    .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na),
    .mem_mask(mem_mask_na), .mem_wdata(mem_wdata_na),
    .mem_gnt(mem_gnt_na), .mem_rvalid(mem_rvalid_na), .mem_rdata(mem_rdata_na)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and play memory until done.
  // gnt_stall idle cycles precede each grant; rvalid follows a grant by one cycle.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_stall, input logic [31:0] w1, input logic [31:0] w2);
    int          cyc, stall, pend_idx;
    logic        pend, holding, seen_done;
    logic [68:0] snap;
    nbeats = 0; stab_bad = 0; req_seen = 1'b0; lat = -1;
    res_rdata = '0; res_err = 1'b0;
    pend = 1'b0; pend_idx = 0; holding = 1'b0; snap = '0; seen_done = 1'b0;
    stall = gnt_stall;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (mem_req) req_seen = 1'b1;
      if (done) begin
        seen_done = 1'b1; lat = cyc; res_rdata = rdata; res_err = err;
        break;
      end
      mem_rvalid = pend;
      mem_rdata  = pend ? ((pend_idx == 0) ? w1 : w2) : 32'h0;
      pend = 1'b0;
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (!holding) begin
          snap = {mem_we, mem_addr, mem_mask, mem_wdata};
          holding = 1'b1;
        end else if ({mem_we, mem_addr, mem_mask, mem_wdata} !== snap) begin
          stab_bad++;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          mem_gnt = 1'b1;
          if (nbeats < 2) begin
            b_addr[nbeats] = mem_addr; b_mask[nbeats] = mem_mask;
            b_wdata[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
          end
          pend = 1'b1; pend_idx = nbeats; nbeats++;
          holding = 1'b0; stall = gnt_stall;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_valid_na = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_gnt_na = 1'b0; mem_rvalid_na = 1'b0; mem_rdata_na = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",   64'(ready),    64'd1);
    check("rst_done",    64'(done),     64'd0);
    check("rst_err",     64'(err),      64'd0);
    check("rst_mem_req", 64'(mem_req),  64'd0);
    check("rst_mask",    64'(mem_mask), 64'd0);
    check("rst_addr",    64'(mem_addr), 64'd0);
    check("rst_rdata",   64'(rdata),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // SW 0x100, zero-wait
    run_access("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    check("sw_beats", 64'(nbeats),     64'd1);
    check("sw_addr",  64'(b_addr[0]),  64'h100);
    check("sw_mask",  64'(b_mask[0]),  64'hF);
    check("sw_wdata", 64'(b_wdata[0]), 64'hDEADBEEF);
    check("sw_we",    64'(b_we[0]),    64'd1);
    check("sw_lat",   64'(lat),        64'd3);
    check("sw_rdata", 64'(res_rdata),  64'd0);
    check("sw_err",   64'(res_err),    64'd0);

    // LB / LBU at 0x203
    run_access("lb", 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF_0000, 32'h0);
    check("lb_addr",  64'(b_addr[0]), 64'h200);
    check("lb_mask",  64'(b_mask[0]), 64'h8);
    check("lb_we",    64'(b_we[0]),   64'd0);
    check("lb_rdata", 64'(res_rdata), 64'hFFFFFF80);
    run_access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF_0000, 32'h0);
    check("lbu_rdata", 64'(res_rdata), 64'h00000080);

    // LH at 0x002 sign-extends, LHU zero-extends
    run_access("lh", 1'b0, 3'b001, 32'h002, 32'h0, 0, 32'h8001_1234, 32'h0);
    check("lh_mask",   64'(b_mask[0]), 64'hC);
    check("lh_rdata",  64'(res_rdata), 64'hFFFF8001);
    run_access("lhu", 1'b0, 3'b101, 32'h002, 32'h0, 0, 32'h8001_1234, 32'h0);
    check("lhu_rdata", 64'(res_rdata), 64'h00008001);

    // SB at 0x001: only lane 1 carries data, others driven 0
    run_access("sb", 1'b1, 3'b000, 32'h001, 32'h1234_5678, 0, 32'h0, 32'h0);
    check("sb_mask",  64'(b_mask[0]),  64'h2);
    check("sb_wdata", 64'(b_wdata[0]), 64'h00007800);

    // SH at 0x303, split, zero-wait
    run_access("sh", 1'b1, 3'b001, 32'h303, 32'h0000ABCD, 0, 32'h0, 32'h0);
    check("sh_beats",   64'(nbeats),     64'd2);
    check("sh_addr1",   64'(b_addr[0]),  64'h300);
    check("sh_mask1",   64'(b_mask[0]),  64'h8);
    check("sh_wdata1",  64'(b_wdata[0]), 64'hCD000000);
    check("sh_addr2",   64'(b_addr[1]),  64'h304);
    check("sh_mask2",   64'(b_mask[1]),  64'h1);
    check("sh_wdata2",  64'(b_wdata[1]), 64'h000000AB);
    check("sh_we2",     64'(b_we[1]),    64'd1);
    check("sh_lat",     64'(lat),        64'd5);

    // LW at 0x402, split, grant stalled 2 cycles per beat
    run_access("lw_stall", 1'b0, 3'b010, 32'h402, 32'h0, 2, 32'h11223344, 32'h55667788);
    check("lw_stall_beats", 64'(nbeats),    64'd2);
    check("lw_stall_mask1", 64'(b_mask[0]), 64'hC);
    check("lw_stall_mask2", 64'(b_mask[1]), 64'h3);
    check("lw_stall_rdata", 64'(res_rdata), 64'h77881122);
    check("lw_stall_lat",   64'(lat),       64'd9);
    check("lw_stall_hold",  64'(stab_bad),  64'd0);

    // LW at 0xFFFFFFFF: second beat wraps to address 0
    run_access("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 0, 32'hAA00_0000, 32'h0033_2211);
    check("lw_wrap_addr1", 64'(b_addr[0]), 64'hFFFF_FFFC);
    check("lw_wrap_addr2", 64'(b_addr[1]), 64'h0);
    check("lw_wrap_mask2", 64'(b_mask[1]), 64'h7);
    check("lw_wrap_rdata", 64'(res_rdata), 64'h332211AA);

    // Illegal funct3 011
    run_access("f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 0, 32'h0, 32'h0);
    check("f3_011_err",   64'(res_err),  64'd1);
    check("f3_011_lat",   64'(lat),      64'd1);
    check("f3_011_rdata", 64'(res_rdata), 64'd0);
    check("f3_011_mreq",  64'(req_seen), 64'd0);

    // LW at 0x401 with splitting disabled
    @(negedge clk);
    req_valid_na = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h401; req_wdata = '0;
    @(negedge clk);
    req_valid_na = 1'b0;
    check("na_done",  64'(done_na),    64'd1);
    check("na_err",   64'(err_na),     64'd1);
    check("na_mreq",  64'(mem_req_na), 64'd0);
    check("na_rdata", 64'(rdata_na),   64'd0);
    @(negedge clk);
    check("na_done_pulse", 64'(done_na),    64'd0);
    check("na_ready",      64'(ready_na),   64'd1);
    check("na_mreq2",      64'(mem_req_na), 64'd0);
    check("na_bus_idle",   {mem_we_na, mem_addr_na, mem_mask_na, mem_wdata_na}, 64'd0);

    // Reset while waiting for beat 1 of a split load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h402;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(ready),    64'd1);
    check("midrst_mreq",  64'(mem_req),  64'd0);
    check("midrst_mask",  64'(mem_mask), 64'd0);
    check("midrst_addr",  64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("stale_done",  64'(done),  64'd0);
    check("stale_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("stale_done2", 64'(done),    64'd0);
    check("stale_mreq",  64'(mem_req), 64'd0);

    run_access("lw_after", 1'b0, 3'b010, 32'h500, 32'h0, 0, 32'hCAFE_F00D, 32'h0);
    check("lw_after_rdata", 64'(res_rdata), 64'hCAFEF00D);
    check("lw_after_lat",   64'(lat),       64'd3);
    check("lw_after_beats", 64'(nbeats),    64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_split_access.md
LSU_SPLIT_ACCESS -- requirements
Module: lsu_split_access

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width; data width is fixed at 32.
REQ-002 Parameter MISALIGN_EN, default 1: 1 = split accesses that cross a word boundary; 0 = flag them as errors.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req_valid  in  1  pipeline access request; sampled only while ready=1.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 req_addr  in  ADDR_W  byte address (ALU result).
REQ-009 req_wdata  in  32  store data (rs2), right-aligned.
REQ-010 ready  out  1  high only in IDLE; low means stall the pipeline.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; illegal funct3, or misaligned access with MISALIGN_EN=0.
REQ-013 rdata  out  32  extended load result; valid with done; 0 for stores and errors.
REQ-014 mem_req  out  1  memory request; held until mem_gnt.
REQ-015 mem_we  out  1  store beat.
REQ-016 mem_addr  out  ADDR_W  word-aligned address, with [1:0] = 00.
REQ-017 mem_mask  out  4  byte enables; bit i covers bits [8i+7:8i].
REQ-018 mem_wdata  out  32  lane-shifted store data.
REQ-019 mem_gnt  in  1  memory accepts the beat while mem_req=1.
REQ-020 mem_rvalid  in  1  beat response: load data or store ack; at least 1 cycle after mem_gnt.
REQ-021 mem_rdata  in  32  load beat data; valid with mem_rvalid.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, on req_valid: capture all request fields and go to ISSUE; for an error request, go directly to RESP and make no memory access.
- ISSUE: assert mem_req; on mem_gnt go to WAIT.
- WAIT: on mem_rvalid, if a second beat is pending go to ISSUE, otherwise go to RESP.
- RESP: assert done for one cycle, then return to IDLE.
REQ-023 Byte offset off = addr[1:0]; size = 1/2/4 bytes for byte/half/word codes. The access splits into two beats when off + size > 4, which applies only when MISALIGN_EN=1.
REQ-024 Beat 1 goes to {addr[ADDR_W-1:2],00}; beat 2 goes to beat-1 address + 4, wrapping modulo 2^ADDR_W.
REQ-025 Byte enables: the full byte mask is ((1<<size)-1) << off, taken over 8 bits. Beat 1 mask = bits [3:0]; beat 2 mask = bits [7:4].
REQ-026 Store data: the 64-bit value {32'b0, wdata} << 8*off supplies both beats. Beat 1 carries [31:0]; beat 2 carries [63:32].
- Masked-off lanes of mem_wdata SHALL be driven 0.
REQ-027 Load assembly:
- Form {beat2, beat1}; beat2 is 0 when the access is not split.
- Shift right by 8*off.
- Take the low size bytes, then sign-extend (funct3 000/001) or zero-extend (100/101).
REQ-028 Latency, aligned access with mem_gnt in the same cycle and mem_rvalid the next cycle: request accepted at edge N, done high in cycle N+3.
- A split access adds 2 cycles.
- Each extra stall cycle on mem_gnt or mem_rvalid adds 1 cycle.
REQ-029 An error request: done=err=1 in the cycle after acceptance; mem_req stays 0.
REQ-030 mem_rvalid received in IDLE, ISSUE or RESP is ignored; mem_gnt received while mem_req=0 is ignored.
REQ-031 mem_addr, mem_mask, mem_wdata and mem_we SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-032 req_valid arriving while ready=0 is not sampled; the pipeline holds it.

Reset
REQ-033 When rst is asserted, at any state including mid-beat:
- the FSM returns to IDLE;
- ready=1;
- done=err=mem_req=mem_we=0;
- mem_mask=0, mem_addr=0, mem_wdata=0, rdata=0;
- the captured request and the beat-1 buffer are cleared.
REQ-034 A response arriving after reset is released SHALL be ignored; no stale done.

Structure
REQ-035 Shared package lsu_pkg SHALL hold:
- the funct3 size/sign constants;
- the load/store opcode constants;
- the FSM state enum;
- a size-decode function.
REQ-036 Sub-module lsu_align (combinational) SHALL do the mask, store-shift and load-extract/extend; lsu_split_access holds the FSM and the registers.

Verification
REQ-037 SW at 0x100, wdata 0xDEADBEEF, zero-wait memory -> one beat: addr 0x100, mask 1111, wdata 0xDEADBEEF; done in cycle N+3.
REQ-038 LB at 0x203 with mem word 0x80FF_0000 -> mask 1000, rdata 0xFFFFFF80; LBU with the same inputs -> rdata 0x00000080.
REQ-039 SH at 0x303, wdata 0x0000ABCD, MISALIGN_EN=1 ->
- beat 1: addr 0x300, mask 1000, wdata 0xCD000000;
- beat 2: addr 0x304, mask 0001, wdata 0x000000AB.
REQ-040 LW at 0x402, beat 1 = 0x11223344, beat 2 = 0x55667788, mem_gnt stalled 2 cycles -> rdata 0x77881122; done 4 cycles after the zero-wait case.
REQ-041 funct3=011, or LW at 0x401 with MISALIGN_EN=0 -> done=err=1 one cycle after acceptance, mem_req never asserted.
REQ-042 rst asserted in WAIT of a split load, then a mem_rvalid after release -> IDLE, ready=1, no done; the next LW completes normally.
